// File: rtl/comp_flag_gen_if.sv
// rtl/comp_flag_gen_if.sv - compare request/result bundle for comp_flag_gen
// Signals:
//   start    : request a compare (driven by master)
//   a, b     : WIDTH-bit operands (driven by master)
//   sign     : 1 = two's-complement compare, 0 = unsigned (driven by master)
//   busy     : compare in progress (driven by slave)
//   done     : one-cycle pulse, flags valid from this cycle (driven by slave)
//   less_out : A < B (driven by slave)
//   eql_out  : A == B (driven by slave)
interface comp_flag_gen_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sign;
  logic             busy;
  logic             done;
  logic             less_out;
  logic             eql_out;

  modport master (
    output start, a, b, sign,
    input  busy, done, less_out, eql_out
  );

  modport slave (
    input  start, a, b, sign,
    output busy, done, less_out, eql_out
  );
endinterface

// File: rtl/comp_flag_gen.sv
// rtl/comp_flag_gen.sv - iterative MSB-first magnitude comparator producing less/eql flags
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : comp_flag_gen_if slave (start/a/b/sign in, busy/done/less_out/eql_out out)
// Greater-than is reported as less_out=0, eql_out=0.
module comp_flag_gen #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  comp_flag_gen_if.slave  bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDXW-1:0]  r_idx;
  logic             r_done;
  logic             r_less;
  logic             r_eql;

  logic [DIGIT-1:0] w_dig_a;
  logic [DIGIT-1:0] w_dig_b;
  logic             w_accept;
  logic             w_differ;
  logic             w_last;
  logic             w_decide;

  // Operands are shifted left each SCAN cycle, so the digit under test is
  // always the top DIGIT bits; r_idx only tracks how many digits remain.
  assign w_dig_a  = r_a[WIDTH-1 -: DIGIT];
  assign w_dig_b  = r_b[WIDTH-1 -: DIGIT];
  assign w_differ = (w_dig_a != w_dig_b);
  assign w_last   = (r_idx == '0);
  assign w_accept = (r_state == S_IDLE) && bus.start;
  assign w_decide = (r_state == S_SCAN) && (w_differ || w_last);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bus.start) w_state_nxt = S_SCAN;
      S_SCAN: if (w_differ || w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs: busy decodes the state, the rest come straight from registers
  always_comb begin
    bus.busy     = (r_state == S_SCAN);
    bus.done     = r_done;
    bus.less_out = r_less;
    bus.eql_out  = r_eql;
  end

  // Operand, digit-index and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_idx  <= '0;
      r_done <= 1'b0;
      r_less <= 1'b0;
      r_eql  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        // Flipping both MSBs maps two's-complement order onto unsigned order.
        r_a   <= bus.a ^ (bus.sign ? MSB_MASK : '0);
        r_b   <= bus.b ^ (bus.sign ? MSB_MASK : '0);
        r_idx <= IDXW'(NDIG - 1);
      end else if (w_decide) begin
        r_done <= 1'b1;
        r_less <= (w_dig_a < w_dig_b);
        r_eql  <= !w_differ;
      end else if (r_state == S_SCAN) begin
        r_a   <= r_a << DIGIT;
        r_b   <= r_b << DIGIT;
        r_idx <= r_idx - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_comp_flag_gen.sv
// tb/tb_comp_flag_gen.sv - self-checking bench for comp_flag_gen (DIGIT 4, 1 and 8)
module tb_comp_flag_gen;

  logic        clk;
  logic        rst_n;
  logic        s_start;
  logic [31:0] s_a;
  logic [31:0] s_b;
  logic        s_sign;

  int n_tests;
  int n_fail;

  comp_flag_gen_if #(.WIDTH(32)) if4 ();
  comp_flag_gen_if #(.WIDTH(32)) if1 ();
  comp_flag_gen_if #(.WIDTH(32)) if8 ();

  assign if4.start = s_start;
  assign if4.a     = s_a;
  assign if4.b     = s_b;
  assign if4.sign  = s_sign;
  assign if1.start = s_start;
  assign if1.a     = s_a;
  assign if1.b     = s_b;
  assign if1.sign  = s_sign;
  assign if8.start = s_start;
  assign if8.a     = s_a;
  assign if8.b     = s_b;
  assign if8.sign  = s_sign;

  comp_flag_gen #(.WIDTH(32), .DIGIT(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  comp_flag_gen #(.WIDTH(32), .DIGIT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  comp_flag_gen #(.WIDTH(32), .DIGIT(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sg;
    logic        less;
    logic        eql;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: ordering straight from integer comparison, latency from the
  // position of the first differing DIGIT-wide slice counted from the top.
  function automatic int ref_less(input logic [31:0] a, input logic [31:0] b, input logic sg);
    if (sg) return ($signed(a) < $signed(b)) ? 1 : 0;
    return (a < b) ? 1 : 0;
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input int d);
    int nd;
    logic [31:0] mask;
    nd   = 32 / d;
    mask = (d == 32) ? 32'hFFFF_FFFF : ((32'd1 << d) - 32'd1);
    for (int k = 0; k < nd; k++) begin
      int sh;
      sh = (nd - 1 - k) * d;
      if ((((a >> sh) ^ (b >> sh)) & mask) != 32'd0) return k + 1;
    end
    return nd;
  endfunction

  // Launches one compare on all three instances and records each latency
  // (posedges after the accept edge until done is seen), -1 on timeout.
  task automatic run_cmp(input logic [31:0] a, input logic [31:0] b, input logic sg,
                         output int lat4, output int lat1, output int lat8);
    lat4 = -1; lat1 = -1; lat8 = -1;
    @(negedge clk);
    s_a = a; s_b = b; s_sign = sg; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (if4.done && lat4 < 0) lat4 = c;
      if (if1.done && lat1 < 0) lat1 = c;
      if (if8.done && lat8 < 0) lat8 = c;
      if (lat4 >= 0 && lat1 >= 0 && lat8 >= 0) break;
    end
  endtask

  initial begin
    int l4, l1, l8;
    int lat;
    int ok;
    int pulses;

    n_tests = 0;
    n_fail  = 0;
    s_start = 1'b0; s_a = '0; s_b = '0; s_sign = 1'b0;

    vecs[0] = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 8};
    vecs[1] = '{32'h80000000, 32'h00000001, 1'b0, 1'b0, 1'b0, 1};
    vecs[2] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 1'b0, 1};
    vecs[3] = '{32'h12345677, 32'h12345678, 1'b0, 1'b1, 1'b0, 8};
    vecs[4] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1, 1'b0, 1};
    vecs[5] = '{32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 1};
    vecs[6] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b0, 1'b0, 1};
    vecs[7] = '{32'h00010000, 32'h00020000, 1'b0, 1'b1, 1'b0, 4};
    vecs[8] = '{32'h00000005, 32'h00000005, 1'b1, 1'b0, 1'b1, 8};
    vecs[9] = '{32'hFFFF0000, 32'hFFFE0000, 1'b1, 1'b0, 1'b0, 4};

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(if4.busy), 0);
    check("reset_done", int'(if4.done), 0);
    check("reset_less", int'(if4.less_out), 0);
    check("reset_eql",  int'(if4.eql_out), 0);
    rst_n = 1'b1;

    // Directed table on the DIGIT=4 instance
    foreach (vecs[i]) begin
      run_cmp(vecs[i].a, vecs[i].b, vecs[i].sg, l4, l1, l8);
      check($sformatf("vec%0d_lat", i),  l4, vecs[i].lat);
      check($sformatf("vec%0d_less", i), int'(if4.less_out), int'(vecs[i].less));
      check($sformatf("vec%0d_eql", i),  int'(if4.eql_out), int'(vecs[i].eql));
    end

    // start while busy is ignored
    @(negedge clk);
    s_a = 32'h1; s_b = 32'h2; s_sign = 1'b0; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin s_a = 32'hFFFFFFFF; s_b = 32'h0; s_start = 1'b1; end
      if (c == 2) s_start = 1'b0;
      if (if4.done && lat < 0) begin lat = c; break; end
    end
    check("busy_start_lat", lat, 8);
    check("busy_start_less", int'(if4.less_out), 1);
    check("busy_start_eql", int'(if4.eql_out), 0);
    pulses = 0;
    ok = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      s_a = $urandom; s_b = $urandom; s_sign = 1'($urandom);
      if (if4.done) pulses++;
      if (if4.less_out !== 1'b1 || if4.eql_out !== 1'b0) ok = 0;
    end
    check("busy_start_not_queued", pulses, 0);
    check("flags_hold", ok, 1);

    // start in the done cycle is accepted
    @(negedge clk);
    s_a = 32'h10000000; s_b = 32'h0; s_sign = 1'b0; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (if4.done) begin lat = c; break; end
    end
    check("pre_done_lat", lat, 1);
    s_a = 32'd5; s_b = 32'd5; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    check("b2b_busy", int'(if4.busy), 1);
    check("b2b_done_fell", int'(if4.done), 0);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (if4.done) begin lat = c; break; end
    end
    check("b2b_lat", lat, 8);
    check("b2b_eql", int'(if4.eql_out), 1);

    // Asynchronous reset mid-SCAN
    @(negedge clk);
    s_a = 32'hDEADBEEF; s_b = 32'hDEADBEEF; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_scan_busy", int'(if4.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", int'(if4.busy), 0);
    check("async_rst_done", int'(if4.done), 0);
    check("async_rst_less", int'(if4.less_out), 0);
    check("async_rst_eql",  int'(if4.eql_out), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (if4.done || if4.busy) pulses++;
    end
    check("post_rst_idle", pulses, 0);
    run_cmp(32'h12345677, 32'h12345678, 1'b0, l4, l1, l8);
    check("post_rst_lat", l4, 8);
    check("post_rst_less", int'(if4.less_out), 1);

    // Randomized sweep against the reference on all three digit sizes
    for (int n = 0; n < 1000; n++) begin
      logic [31:0] ra, rb;
      logic        rs;
      int          el;
      ra = $urandom;
      rs = 1'($urandom);
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = ra;
        2: rb = ra ^ (32'd1 << $urandom_range(0, 31));
        default: rb = ra ^ ($urandom & ((32'd1 << $urandom_range(1, 31)) - 32'd1));
      endcase
      el = ref_less(ra, rb, rs);
      run_cmp(ra, rb, rs, l4, l1, l8);
      check("rnd_d4_lat", l4, ref_lat(ra, rb, 4));
      check("rnd_d1_lat", l1, ref_lat(ra, rb, 1));
      check("rnd_d8_lat", l8, ref_lat(ra, rb, 8));
      check("rnd_d4_less", int'(if4.less_out), el);
      check("rnd_d1_less", int'(if1.less_out), el);
      check("rnd_d8_less", int'(if8.less_out), el);
      check("rnd_d4_eql", int'(if4.eql_out), (ra == rb) ? 1 : 0);
      check("rnd_d1_eql", int'(if1.eql_out), (ra == rb) ? 1 : 0);
      check("rnd_d8_eql", int'(if8.eql_out), (ra == rb) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
